// File: rtl/simple_dram_frontend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Packages : ShellTypes, AMITypes                                            |
// | Purpose  : Shared types for the SimpleDRAM frontend.                       |
// |            ShellTypes - MemReq / MemResp request and response records.     |
// |            AMITypes   - default queue depths and the DRAM command record   |
// |                         held in the request queue.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ShellTypes;

  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [63:0]  addr;
    logic [511:0] data;
  } MemReq;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } MemResp;

endpackage

package AMITypes;

  localparam int SIMPLE_DRAM_FE_REQ_LOG_DEPTH  = 3;
  localparam int SIMPLE_DRAM_FE_RESP_LOG_DEPTH = 3;

  // Request queue payload: everything from MemReq except the valid bit.
  typedef struct packed {
    logic         isWrite;
    logic [63:0]  addr;
    logic [511:0] data;
  } DramCmd;

endpackage
`default_nettype wire

// File: rtl/simple_dram_fe_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : simple_dram_fe_fifo                                             |
// | Purpose  : Synchronous FIFO of 2^LOG_DEPTH entries with occupancy count.   |
// |            Head is presented combinationally from storage; a push into an  |
// |            empty FIFO is visible at the head the following cycle.          |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            enq_i/enq_data_i - push (ignored when full)                     |
// |            deq_i            - pop (ignored when empty)                     |
// |            head_o           - oldest entry                                 |
// |            empty_o, count_o - occupancy status                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module simple_dram_fe_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_i,
  input  logic [WIDTH-1:0]     enq_data_i,
  input  logic                 deq_i,
  output logic [WIDTH-1:0]     head_o,
  output logic                 empty_o,
  output logic [LOG_DEPTH:0]   count_o
);

  localparam int                DEPTH      = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_enq;
  logic                 do_deq;

  assign do_enq = enq_i && (count_q != FULL_COUNT);
  assign do_deq = deq_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous push and pop leaves occupancy unchanged.
    if (do_enq && !do_deq)      count_d = count_q + 1'b1;
    else if (!do_enq && do_deq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/simple_dram_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : simple_dram_frontend                                            |
// | Purpose  : Queues MemReq traffic toward a DRAM model and returns read data |
// |            in order. Reads are only issued when the response queue is      |
// |            guaranteed room (credit = in-flight reads + queued responses).  |
// | Ports    : clk, rst                 - clock, synchronous active-high reset |
// |            reqIn / reqIn_grant      - request in, accepted this cycle      |
// |            respOut / respOut_grant  - read data out, consumed this cycle   |
// |            dram_req_* / ready       - command to DRAM model                |
// |            dram_resp_valid/_data    - in-order read return, no backpressure|
// |            protocol_err             - sticky: unexpected DRAM response     |
// |            stat_reads/writes/stall  - statistics counters                  |
// | Options  : SIMPLE_DRAM_FE_STATS_EN - when defined, statistics counters are |
// |            built; otherwise stat_* are tied to zero.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module simple_dram_frontend
  import ShellTypes::*;
  import AMITypes::*;
#(
  parameter int REQ_LOG_DEPTH  = SIMPLE_DRAM_FE_REQ_LOG_DEPTH,
  parameter int RESP_LOG_DEPTH = SIMPLE_DRAM_FE_RESP_LOG_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  MemReq         reqIn,
  output logic          reqIn_grant,
  output MemResp        respOut,
  input  logic          respOut_grant,
  output logic          dram_req_valid,
  output logic          dram_req_isWrite,
  output logic [63:0]   dram_req_addr,
  output logic [511:0]  dram_req_data,
  input  logic          dram_req_ready,
  input  logic          dram_resp_valid,
  input  logic [511:0]  dram_resp_data,
  output logic          protocol_err,
  output logic [31:0]   stat_reads,
  output logic [31:0]   stat_writes,
  output logic [31:0]   stat_stall
);

  localparam int                       CMD_W        = $bits(DramCmd);
  localparam logic [REQ_LOG_DEPTH:0]    REQ_FULL     = {1'b1, {REQ_LOG_DEPTH{1'b0}}};
  localparam logic [RESP_LOG_DEPTH+1:0] CREDIT_LIMIT = {2'b01, {RESP_LOG_DEPTH{1'b0}}};

  // ---------------- request queue ----------------
  DramCmd                   req_enq_data;
  logic [CMD_W-1:0]         req_head_bits;
  DramCmd                   req_head;
  logic                     req_empty;
  logic [REQ_LOG_DEPTH:0]   req_count;
  logic                     req_full;
  logic                     dram_issue;
  logic                     rd_issue;

  assign req_enq_data = '{isWrite: reqIn.isWrite, addr: reqIn.addr, data: reqIn.data};
  assign req_full     = (req_count == REQ_FULL);
  // No same-cycle bypass: a full queue refuses even while it is draining.
  assign reqIn_grant  = !rst && reqIn.valid && !req_full;

  simple_dram_fe_fifo #(
    .WIDTH     (CMD_W),
    .LOG_DEPTH (REQ_LOG_DEPTH)
  ) u_req_q (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (reqIn_grant),
    .enq_data_i (req_enq_data),
    .deq_i      (dram_issue),
    .head_o     (req_head_bits),
    .empty_o    (req_empty),
    .count_o    (req_count)
  );

  assign req_head = DramCmd'(req_head_bits);

  // ---------------- read credit ----------------
  logic [RESP_LOG_DEPTH:0]   rd_outstanding_q, rd_outstanding_d;
  logic [RESP_LOG_DEPTH:0]   resp_count;
  logic [RESP_LOG_DEPTH+1:0] credit_used;
  logic                      credit_ok;

  // One extra bit so the sum of two full-range counters cannot wrap.
  assign credit_used = {1'b0, rd_outstanding_q} + {1'b0, resp_count};
  assign credit_ok   = (credit_used < CREDIT_LIMIT);

  assign dram_req_valid   = !rst && !req_empty && (req_head.isWrite || credit_ok);
  assign dram_req_isWrite = req_head.isWrite;
  assign dram_req_addr    = req_head.addr;
  assign dram_req_data    = req_head.data;
  assign dram_issue       = dram_req_valid && dram_req_ready;
  assign rd_issue         = dram_issue && !req_head.isWrite;

  // ---------------- response path ----------------
  logic         resp_accept;
  logic         resp_stray;
  logic [511:0] resp_head;
  logic         resp_empty;
  logic         resp_deq;
  logic         protocol_err_q, protocol_err_d;

  // A response with nothing outstanding has no owner: flag it and drop it.
  assign resp_stray  = dram_resp_valid && (rd_outstanding_q == '0);
  assign resp_accept = dram_resp_valid && !resp_stray;

  assign respOut  = '{valid: !rst && !resp_empty, data: resp_head};
  assign resp_deq = respOut.valid && respOut_grant;

  simple_dram_fe_fifo #(
    .WIDTH     (512),
    .LOG_DEPTH (RESP_LOG_DEPTH)
  ) u_resp_q (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (resp_accept),
    .enq_data_i (dram_resp_data),
    .deq_i      (resp_deq),
    .head_o     (resp_head),
    .empty_o    (resp_empty),
    .count_o    (resp_count)
  );

  always_comb begin
    rd_outstanding_d = rd_outstanding_q;
    if (rd_issue && !resp_accept)      rd_outstanding_d = rd_outstanding_q + 1'b1;
    else if (!rd_issue && resp_accept) rd_outstanding_d = rd_outstanding_q - 1'b1;
    protocol_err_d = protocol_err_q || resp_stray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_outstanding_q <= '0;
      protocol_err_q   <= 1'b0;
    end else begin
      rd_outstanding_q <= rd_outstanding_d;
      protocol_err_q   <= protocol_err_d;
    end
  end

  assign protocol_err = protocol_err_q;

  // ---------------- statistics ----------------
`ifdef SIMPLE_DRAM_FE_STATS_EN
  logic [31:0] stat_reads_q;
  logic [31:0] stat_writes_q;
  logic [31:0] stat_stall_q;

  // All counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (rd_issue && (stat_reads_q != '1))
        stat_reads_q <= stat_reads_q + 32'd1;
      if (dram_issue && req_head.isWrite && (stat_writes_q != '1))
        stat_writes_q <= stat_writes_q + 32'd1;
      if (dram_req_valid && !dram_req_ready && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_dram_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_simple_dram_frontend                                         |
// | Purpose  : Self-checking bench for simple_dram_frontend. Expected DRAM     |
// |            commands and read responses are queued as stimulus is driven    |
// |            and compared against the handshakes seen on the DUT outputs.    |
// | Options  : SIMPLE_DRAM_FE_STATS_EN selects the expected statistics values. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_simple_dram_frontend;
  import ShellTypes::*;

  typedef logic [576:0] cmd_t;

  logic         clk = 1'b0;
  logic         rst;
  MemReq        reqIn;
  logic         reqIn_grant;
  MemResp       respOut;
  logic         respOut_grant;
  logic         dram_req_valid;
  logic         dram_req_isWrite;
  logic [63:0]  dram_req_addr;
  logic [511:0] dram_req_data;
  logic         dram_req_ready;
  logic         dram_resp_valid;
  logic [511:0] dram_resp_data;
  logic         protocol_err;
  logic [31:0]  stat_reads, stat_writes, stat_stall;

  int checks   = 0;
  int failures = 0;

  cmd_t         exp_cmd[$];
  cmd_t         obs_cmd[$];
  logic [511:0] exp_resp[$];
  logic [511:0] obs_resp[$];

`ifdef SIMPLE_DRAM_FE_STATS_EN
  localparam logic [31:0] EXP_READS = 32'd3, EXP_WRITES = 32'd2, EXP_STALL = 32'd4;
`else
  localparam logic [31:0] EXP_READS = 32'd0, EXP_WRITES = 32'd0, EXP_STALL = 32'd0;
`endif

  simple_dram_frontend dut (
    .clk              (clk),
    .rst              (rst),
    .reqIn            (reqIn),
    .reqIn_grant      (reqIn_grant),
    .respOut          (respOut),
    .respOut_grant    (respOut_grant),
    .dram_req_valid   (dram_req_valid),
    .dram_req_isWrite (dram_req_isWrite),
    .dram_req_addr    (dram_req_addr),
    .dram_req_data    (dram_req_data),
    .dram_req_ready   (dram_req_ready),
    .dram_resp_valid  (dram_resp_valid),
    .dram_resp_data   (dram_resp_data),
    .protocol_err     (protocol_err),
    .stat_reads       (stat_reads),
    .stat_writes      (stat_writes),
    .stat_stall       (stat_stall)
  );

  always #5 clk = ~clk;

  function automatic MemReq mk_req(logic w, logic [63:0] a, logic [511:0] d);
    MemReq r;
    r.valid   = 1'b1;
    r.isWrite = w;
    r.addr    = a;
    r.data    = d;
    return r;
  endfunction

  function automatic cmd_t cmd_of(MemReq r);
    return {r.isWrite, r.addr, r.data};
  endfunction

  // Record handshakes at the falling edge, then advance to just past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (dram_req_valid && dram_req_ready)
      obs_cmd.push_back({dram_req_isWrite, dram_req_addr, dram_req_data});
    if (respOut.valid && respOut_grant)
      obs_resp.push_back(respOut.data);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reqIn           = '0;
    dram_resp_valid = 1'b0;
    dram_resp_data  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_cmd.delete();
    obs_cmd.delete();
    exp_resp.delete();
    obs_resp.delete();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    idle_inputs();
    reqIn          = mk_req(1'b0, 64'h40, '0);
    dram_req_ready = 1'b1;
    respOut_grant  = 1'b1;
    tick();
    #1;
    checks++; if (reqIn_grant !== 1'b0) begin failures++; $display("FAIL rst_grant: got %b expected 0", reqIn_grant); end
    checks++; if (dram_req_valid !== 1'b0) begin failures++; $display("FAIL rst_dram_valid: got %b expected 0", dram_req_valid); end
    checks++; if (respOut.valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b expected 0", respOut.valid); end
    tick();
    #1;
    checks++; if (reqIn_grant !== 1'b0) begin failures++; $display("FAIL rst_grant2: got %b expected 0", reqIn_grant); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", protocol_err); end
    checks++; if ({stat_reads, stat_writes, stat_stall} !== 96'd0) begin failures++; $display("FAIL rst_stats: got %0h expected 0", {stat_reads, stat_writes, stat_stall}); end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++; if (obs_cmd.size() != 0) begin failures++; $display("FAIL rst_no_cmd: got %0d expected 0", obs_cmd.size()); end
  endtask

  task automatic test_single_read();
    logic [511:0] d;
    apply_reset();
    dram_req_ready = 1'b1;
    respOut_grant  = 1'b1;
    reqIn = mk_req(1'b0, 64'h40, '0);
    exp_cmd.push_back(cmd_of(reqIn));
    #1;
    checks++; if (reqIn_grant !== 1'b1) begin failures++; $display("FAIL sr_grant: got %b expected 1", reqIn_grant); end
    checks++; if (dram_req_valid !== 1'b0) begin failures++; $display("FAIL sr_min_latency: got %b expected 0", dram_req_valid); end
    tick();
    reqIn = '0;
    #1;
    checks++; if (dram_req_valid !== 1'b1 || dram_req_addr !== 64'h40 || dram_req_isWrite !== 1'b0) begin
      failures++; $display("FAIL sr_issue: got v=%b a=%0h w=%b expected v=1 a=40 w=0", dram_req_valid, dram_req_addr, dram_req_isWrite);
    end
    tick(); tick(); tick();
    d = {16{32'hA5A5A5A5}};
    dram_resp_valid = 1'b1;
    dram_resp_data  = d;
    exp_resp.push_back(d);
    #1;
    checks++; if (respOut.valid !== 1'b0) begin failures++; $display("FAIL sr_resp_early: got %b expected 0", respOut.valid); end
    tick();
    dram_resp_valid = 1'b0;
    #1;
    checks++; if (respOut.valid !== 1'b1 || respOut.data !== d) begin failures++; $display("FAIL sr_resp: got v=%b d=%0h expected v=1 d=%0h", respOut.valid, respOut.data, d); end
    tick();
    #1;
    checks++; if (respOut.valid !== 1'b0) begin failures++; $display("FAIL sr_resp_drain: got %b expected 0", respOut.valid); end
    checks++; if (obs_cmd.size() != exp_cmd.size()) begin failures++; $display("FAIL sr_cmd_count: got %0d expected %0d", obs_cmd.size(), exp_cmd.size()); end
    foreach (exp_cmd[k]) if (k < obs_cmd.size()) begin
      checks++; if (obs_cmd[k] !== exp_cmd[k]) begin failures++; $display("FAIL sr_cmd[%0d]: got %0h expected %0h", k, obs_cmd[k], exp_cmd[k]); end
    end
    checks++; if (obs_resp.size() != exp_resp.size()) begin failures++; $display("FAIL sr_resp_count: got %0d expected %0d", obs_resp.size(), exp_resp.size()); end
    foreach (exp_resp[k]) if (k < obs_resp.size()) begin
      checks++; if (obs_resp[k] !== exp_resp[k]) begin failures++; $display("FAIL sr_resp[%0d]: got %0h expected %0h", k, obs_resp[k], exp_resp[k]); end
    end
  endtask

  task automatic test_req_full();
    cmd_t first;
    apply_reset();
    dram_req_ready = 1'b0;
    respOut_grant  = 1'b1;
    first = cmd_of(mk_req(1'b1, 64'h1000, {16{32'hC0DE0000}}));
    for (int i = 0; i < 11; i++) begin
      int   idx;
      logic g;
      idx   = (i < 8) ? i : 8;
      g     = (i < 8);
      reqIn = mk_req(1'b1, 64'h1000 + 64'(idx * 64), {16{32'hC0DE0000 + 32'(idx)}});
      #1;
      checks++; if (reqIn_grant !== g) begin failures++; $display("FAIL full_grant[%0d]: got %b expected %b", i, reqIn_grant, g); end
      if (g) exp_cmd.push_back(cmd_of(reqIn));
      if (i >= 1) begin
        checks++;
        if (dram_req_valid !== 1'b1 || {dram_req_isWrite, dram_req_addr, dram_req_data} !== first) begin
          failures++; $display("FAIL full_stable[%0d]: got v=%b a=%0h expected v=1 a=1000", i, dram_req_valid, dram_req_addr);
        end
      end
      tick();
    end
    reqIn          = '0;
    dram_req_ready = 1'b1;
    repeat (12) tick();
    checks++; if (obs_cmd.size() != exp_cmd.size()) begin failures++; $display("FAIL full_cmd_count: got %0d expected %0d", obs_cmd.size(), exp_cmd.size()); end
    foreach (exp_cmd[k]) if (k < obs_cmd.size()) begin
      checks++; if (obs_cmd[k] !== exp_cmd[k]) begin failures++; $display("FAIL full_cmd[%0d]: got %0h expected %0h", k, obs_cmd[k], exp_cmd[k]); end
    end
  endtask

  task automatic test_credit();
    apply_reset();
    dram_req_ready = 1'b1;
    respOut_grant  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      reqIn = mk_req(1'b0, 64'h2000 + 64'(i * 64), '0);
      exp_cmd.push_back(cmd_of(reqIn));
      #1;
      checks++; if (reqIn_grant !== 1'b1) begin failures++; $display("FAIL cr_grant[%0d]: got %b expected 1", i, reqIn_grant); end
      tick();
    end
    reqIn = '0;
    repeat (3) tick();
    checks++; if (obs_cmd.size() != 8) begin failures++; $display("FAIL cr_issued: got %0d expected 8", obs_cmd.size()); end
    checks++; if (dram_req_valid !== 1'b0) begin failures++; $display("FAIL cr_stall: got %b expected 0", dram_req_valid); end
    dram_resp_valid = 1'b1;
    dram_resp_data  = {16{32'hD0000000}};
    exp_resp.push_back({16{32'hD0000000}});
    tick();
    dram_resp_valid = 1'b0;
    #1;
    checks++; if (respOut.valid !== 1'b1) begin failures++; $display("FAIL cr_resp_held: got %b expected 1", respOut.valid); end
    checks++; if (dram_req_valid !== 1'b0) begin failures++; $display("FAIL cr_still_stalled: got %b expected 0", dram_req_valid); end
    tick();
    respOut_grant = 1'b1;
    tick();
    #1;
    checks++; if (dram_req_valid !== 1'b1 || dram_req_addr !== 64'h2200) begin failures++; $display("FAIL cr_ninth: got v=%b a=%0h expected v=1 a=2200", dram_req_valid, dram_req_addr); end
    tick();
    for (int i = 1; i < 9; i++) begin
      dram_resp_valid = 1'b1;
      dram_resp_data  = {16{32'hD0000000 + 32'(i)}};
      exp_resp.push_back(dram_resp_data);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    checks++; if (obs_cmd.size() != exp_cmd.size()) begin failures++; $display("FAIL cr_cmd_count: got %0d expected %0d", obs_cmd.size(), exp_cmd.size()); end
    foreach (exp_cmd[k]) if (k < obs_cmd.size()) begin
      checks++; if (obs_cmd[k] !== exp_cmd[k]) begin failures++; $display("FAIL cr_cmd[%0d]: got %0h expected %0h", k, obs_cmd[k], exp_cmd[k]); end
    end
    checks++; if (obs_resp.size() != exp_resp.size()) begin failures++; $display("FAIL cr_resp_count: got %0d expected %0d", obs_resp.size(), exp_resp.size()); end
    foreach (exp_resp[k]) if (k < obs_resp.size()) begin
      checks++; if (obs_resp[k] !== exp_resp[k]) begin failures++; $display("FAIL cr_resp[%0d]: got %0h expected %0h", k, obs_resp[k], exp_resp[k]); end
    end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL cr_err: got %b expected 0", protocol_err); end
  endtask

  task automatic test_interleaved();
    apply_reset();
    dram_req_ready = 1'b1;
    respOut_grant  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reqIn = mk_req((i % 2) == 0, 64'h100 + 64'(i * 64), {16{32'hBEEF0000 + 32'(i)}});
      exp_cmd.push_back(cmd_of(reqIn));
      tick();
    end
    reqIn = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      dram_resp_valid = 1'b1;
      dram_resp_data  = {16{32'h77770000 + 32'(i)}};
      exp_resp.push_back(dram_resp_data);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    checks++; if (obs_cmd.size() != exp_cmd.size()) begin failures++; $display("FAIL il_cmd_count: got %0d expected %0d", obs_cmd.size(), exp_cmd.size()); end
    foreach (exp_cmd[k]) if (k < obs_cmd.size()) begin
      checks++; if (obs_cmd[k] !== exp_cmd[k]) begin failures++; $display("FAIL il_cmd[%0d]: got %0h expected %0h", k, obs_cmd[k], exp_cmd[k]); end
    end
    checks++; if (obs_resp.size() != exp_resp.size()) begin failures++; $display("FAIL il_resp_count: got %0d expected %0d", obs_resp.size(), exp_resp.size()); end
    foreach (exp_resp[k]) if (k < obs_resp.size()) begin
      checks++; if (obs_resp[k] !== exp_resp[k]) begin failures++; $display("FAIL il_resp[%0d]: got %0h expected %0h", k, obs_resp[k], exp_resp[k]); end
    end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    dram_req_ready  = 1'b1;
    respOut_grant   = 1'b1;
    dram_resp_valid = 1'b1;
    dram_resp_data  = {16{32'hDEADBEEF}};
    #1;
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL pe_before: got %b expected 0", protocol_err); end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL pe_sticky[%0d]: got %b expected 1", i, protocol_err); end
      checks++; if (respOut.valid !== 1'b0) begin failures++; $display("FAIL pe_dropped[%0d]: got %b expected 0", i, respOut.valid); end
      tick();
    end
    apply_reset();
    #1;
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL pe_cleared: got %b expected 0", protocol_err); end
    // Read issued, then reset before its data returns: the late data is stray.
    reqIn = mk_req(1'b0, 64'h80, '0);
    tick();
    reqIn = '0;
    tick();
    tick();
    checks++; if (obs_cmd.size() != 1) begin failures++; $display("FAIL pe_pre_issue: got %0d expected 1", obs_cmd.size()); end
    apply_reset();
    dram_resp_valid = 1'b1;
    dram_resp_data  = {16{32'h12345678}};
    tick();
    idle_inputs();
    #1;
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL pe_post_reset: got %b expected 1", protocol_err); end
    checks++; if (respOut.valid !== 1'b0) begin failures++; $display("FAIL pe_post_reset_resp: got %b expected 0", respOut.valid); end
  endtask

  task automatic test_stats();
    apply_reset();
    dram_req_ready = 1'b0;
    respOut_grant  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqIn = mk_req((i % 2) == 1, 64'h3000 + 64'(i * 64), {16{32'h5EED0000 + 32'(i)}});
      exp_cmd.push_back(cmd_of(reqIn));
      tick();
    end
    reqIn          = '0;
    dram_req_ready = 1'b1;
    repeat (8) tick();
    #1;
    checks++; if (stat_reads !== EXP_READS) begin failures++; $display("FAIL st_reads: got %0d expected %0d", stat_reads, EXP_READS); end
    checks++; if (stat_writes !== EXP_WRITES) begin failures++; $display("FAIL st_writes: got %0d expected %0d", stat_writes, EXP_WRITES); end
    checks++; if (stat_stall !== EXP_STALL) begin failures++; $display("FAIL st_stall: got %0d expected %0d", stat_stall, EXP_STALL); end
    checks++; if (obs_cmd.size() != exp_cmd.size()) begin failures++; $display("FAIL st_cmd_count: got %0d expected %0d", obs_cmd.size(), exp_cmd.size()); end
    foreach (exp_cmd[k]) if (k < obs_cmd.size()) begin
      checks++; if (obs_cmd[k] !== exp_cmd[k]) begin failures++; $display("FAIL st_cmd[%0d]: got %0h expected %0h", k, obs_cmd[k], exp_cmd[k]); end
    end
    apply_reset();
    #1;
    checks++; if ({stat_reads, stat_writes, stat_stall} !== 96'd0) begin failures++; $display("FAIL st_cleared: got %0h expected 0", {stat_reads, stat_writes, stat_stall}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_req_full();
    test_credit();
    test_interleaved();
    test_protocol_err();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simple_dram_frontend.md
SIMPLE_DRAM_FRONTEND -- requirements
Module: simple_dram_frontend

Interface
REQ-001 Parameter REQ_LOG_DEPTH, default 3, SHALL set request queue depth to 2^REQ_LOG_DEPTH entries.
REQ-002 Parameter RESP_LOG_DEPTH, default 3, SHALL set response queue depth and read-credit limit to 2^RESP_LOG_DEPTH.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 reqIn  in  MemReq  {valid, isWrite, addr[63:0], data[511:0]} from AMI-to-SimpleDRAM converter.
REQ-006 reqIn_grant  out  1  request accepted this cycle.
REQ-007 respOut  out  MemResp  {valid, data[511:0]} read data back to converter.
REQ-008 respOut_grant  in  1  consumer accepts respOut this cycle.
REQ-009 dram_req_valid / dram_req_isWrite / dram_req_addr[63:0] / dram_req_data[511:0]  out  command to DRAM model.
REQ-010 dram_req_ready  in  1  DRAM accepts command this cycle.
REQ-011 dram_resp_valid in 1, dram_resp_data in 512  read return, in order, no backpressure.
REQ-012 protocol_err  out  1  sticky error flag.
REQ-013 stat_reads, stat_writes, stat_stall  out  32 each  statistics counters.

Function
REQ-014 reqIn_grant SHALL equal reqIn.valid && !reqQ_full, combinational; no bypass when full even if dequeuing same cycle.
REQ-015 Accepted requests SHALL enqueue in arrival order; head issues to DRAM no earlier than the cycle after enqueue (min latency 1 cycle reqIn to dram_req_valid).
REQ-016 dram_req_* SHALL present reqQ head; dram_req_valid = !reqQ_empty && (head.isWrite || credit_ok).
REQ-017 credit_ok SHALL be true when rd_outstanding + respQ_count < 2^RESP_LOG_DEPTH; counters RESP_LOG_DEPTH+1 bits wide.
REQ-018 Head SHALL dequeue only on dram_req_valid && dram_req_ready; dram_req_* SHALL remain stable while valid and not ready.
REQ-019 rd_outstanding SHALL +1 on read issue, -1 on dram_resp_valid, unchanged when both occur in one cycle.
REQ-020 dram_resp_valid SHALL enqueue dram_resp_data into respQ; credit rule guarantees respQ never overflows.
REQ-021 Writes SHALL generate no response.
REQ-022 respOut.valid SHALL equal !respQ_empty; respOut.data SHALL be respQ head; head dequeues on respOut.valid && respOut_grant.
REQ-023 Response arriving into empty respQ SHALL appear on respOut the following cycle.
REQ-024 protocol_err SHALL set and hold when dram_resp_valid arrives with rd_outstanding == 0; that response SHALL be dropped and counter stays 0.
REQ-025 Simultaneous enq and deq on either queue SHALL preserve count and order.

Reset
REQ-026 rst SHALL empty both queues, clear rd_outstanding, protocol_err and all stat counters.
REQ-027 During and the cycle of rst: reqIn_grant, dram_req_valid, respOut.valid SHALL be 0.
REQ-028 Reset mid-operation SHALL discard queued and in-flight state; DRAM responses for pre-reset reads arriving after reset SHALL raise protocol_err.

Configuration
REQ-029 Macro SIMPLE_DRAM_FE_STATS_EN defined: stat_reads/stat_writes SHALL count issued reads/writes; stat_stall SHALL count cycles with dram_req_valid && !dram_req_ready; all saturate at 0xFFFFFFFF.
REQ-030 Macro undefined: stat ports SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-031 Depth defaults SIMPLE_DRAM_FE_REQ_LOG_DEPTH and SIMPLE_DRAM_FE_RESP_LOG_DEPTH SHALL live in AMITypes; MemReq/MemResp remain in ShellTypes.
REQ-032 One sub-module, simple_dram_fe_fifo (WIDTH, LOG_DEPTH, count output), SHALL be instantiated for reqQ and respQ.

Verification
REQ-033 One read addr 0x40, dram_req_ready=1, response 3 cycles later data 0xA5.. -> dram_req_valid cycle 1, respOut.valid 1 cycle after dram_resp_valid with 0xA5...
REQ-034 dram_req_ready=0, 9 requests offered at depth 8 -> 8 grants, 9th held, dram_req_* stable throughout.
REQ-035 9 reads, no DRAM responses, respOut_grant=0 -> exactly 8 issued, 9th stalls; one response consumed -> 9th issues.
REQ-036 Interleaved W,R,W,R -> DRAM order W,R,W,R; exactly 2 responses, in order.
REQ-037 dram_resp_valid with nothing outstanding -> protocol_err=1 held until rst; respOut.valid stays 0.
REQ-038 With SIMPLE_DRAM_FE_STATS_EN, 3 reads, 2 writes, 4 not-ready cycles -> stat_reads=3, stat_writes=2, stat_stall=4; without macro all 0.
